// File: rtl/dffram_wb_adapter.sv
// -----------------------------------------------------------------------------
// dffram_wb_adapter
//
// Wishbone classic (B3, non-pipelined) slave in front of a single-port DFFRAM
// macro. Each accepted bus request turns into exactly one registered RAM
// strobe cycle. Reads wait out the RAM read latency, register Do0 and then
// acknowledge. Every RAM-side output comes straight from a flop, so the bus
// address and data never reach the RAM decoders combinationally.
//
// Transaction timeline (cycle 0 = request accepted in IDLE):
//   write : cycle 1 strobe (WR), cycle 2 ack (ACK)
//   read  : cycle 1 strobe (RD), cycles 2..1+RD_LAT wait (RWAIT),
//           cycle RD_LAT+2 ack (ACK)
//
// Optional feature macro: DFFRAM_WB_POSTED_WR_EN
//   When defined, a write is acknowledged in its own strobe cycle (cycle 1)
//   and WR returns straight to IDLE. Reads are unaffected.
//
// Parameters
//   WSIZE   bytes per word (width of WE0 and wb_sel_i), data width 8*WSIZE
//   AW      word address width, RAM depth 2**AW
//   RD_LAT  cycles from the EN0 cycle to valid Do0, legal range 1..3
//
// Ports
//   CLK, RST         clock (rising edge), asynchronous active-high reset
//   wb_cyc_i/stb_i   bus cycle / strobe
//   wb_we_i          1 = write, 0 = read
//   wb_sel_i         byte enables (ignored on reads)
//   wb_adr_i         word address
//   wb_dat_i         write data
//   wb_dat_o         registered read data
//   wb_ack_o         single-cycle acknowledge
//   EN0, WE0, A0, Di0  registered RAM strobe, byte write enables, addr, data
//   Do0              RAM read data
// -----------------------------------------------------------------------------
module dffram_wb_adapter #(
  parameter int WSIZE  = 4,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [WSIZE-1:0]     wb_sel_i,
  input  logic [AW-1:0]        wb_adr_i,
  input  logic [8*WSIZE-1:0]   wb_dat_i,
  output logic [8*WSIZE-1:0]   wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 EN0,
  output logic [WSIZE-1:0]     WE0,
  output logic [AW-1:0]        A0,
  output logic [8*WSIZE-1:0]   Di0,
  input  logic [8*WSIZE-1:0]   Do0
);

  localparam int DW = 8 * WSIZE;
  // Wide enough to hold RD_LAT-1 for the whole legal range 1..3.
  localparam int CW = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_RWAIT = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic              ack_r;
  logic [DW-1:0]     dat_r;
  logic              en0_r;
  logic [WSIZE-1:0]  we0_r;
  logic [AW-1:0]     a0_r;
  logic [DW-1:0]     di0_r;
  logic              req_s;

  assign req_s = wb_cyc_i & wb_stb_i;

  // Controller: request capture, one-cycle RAM strobes, read wait, ack.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      ack_r   <= 1'b0;
      dat_r   <= '0;
      en0_r   <= 1'b0;
      we0_r   <= '0;
      a0_r    <= '0;
      di0_r   <= '0;
    end else begin
      // Strobes and ack are single-cycle pulses; A0/Di0 hold their values.
      en0_r <= 1'b0;
      we0_r <= '0;
      ack_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (req_s) begin
            // The request is captured directly into the RAM-side registers,
            // so the strobe appears in cycle 1 with no extra pipeline stage.
            a0_r <= wb_adr_i;
            if (wb_we_i) begin
              // A write with no byte enables touches nothing in the RAM
              // but is still acknowledged on the normal schedule.
              en0_r   <= |wb_sel_i;
              we0_r   <= wb_sel_i;
              di0_r   <= wb_dat_i;
`ifdef DFFRAM_WB_POSTED_WR_EN
              ack_r   <= 1'b1;
`endif
              state_r <= S_WR;
            end else begin
              en0_r   <= 1'b1;
              state_r <= S_RD;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end

        S_WR: begin
          // The RAM strobe in this cycle completes regardless of wb_cyc_i.
`ifdef DFFRAM_WB_POSTED_WR_EN
          state_r <= S_IDLE;
`else
          ack_r   <= 1'b1;
          state_r <= S_ACK;
`endif
        end

        S_RD: begin
          cnt_r   <= CW'(RD_LAT - 1);
          state_r <= S_RWAIT;
        end

        S_RWAIT: begin
          if (!wb_cyc_i) begin
            // Master abandoned the cycle: no ack, read data left untouched.
            cnt_r   <= '0;
            state_r <= S_IDLE;
          end else if (cnt_r == {CW{1'b0}}) begin
            // This edge ends cycle 1+RD_LAT, where Do0 is valid.
            dat_r   <= Do0;
            ack_r   <= 1'b1;
            state_r <= S_ACK;
          end else begin
            cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            state_r <= S_RWAIT;
          end
        end

        S_ACK: begin
          state_r <= S_IDLE;
        end

        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Ack is qualified by wb_cyc_i so a master that drops the cycle while the
  // ack flop is set never observes a stray acknowledge.
  assign wb_ack_o = ack_r & wb_cyc_i;
  assign wb_dat_o = dat_r;
  assign EN0      = en0_r;
  assign WE0      = we0_r;
  assign A0       = a0_r;
  assign Di0      = di0_r;

endmodule
